unified_mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between instruction fetch (IF) and load/store (DM) traffic.

---
 rtl/unified_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store traffic.
// DM has priority over IF with a streak limit; a watchdog force-completes hung accesses.
module unified_mem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 255,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_valid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_e;

    localparam logic [CNT_W-1:0] MAX_STREAK_C = CNT_W'(MAX_DM_STREAK);
    localparam logic [CNT_W-1:0] TMO_LAST_C   = CNT_W'(TIMEOUT - 1);
    localparam bit               TMO_EN       = (TIMEOUT != 0);

    state_e              state_q, state_d;
    logic                owner_dm_q, owner_dm_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    streak_q, streak_d;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
    logic                bus_err_q, bus_err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_dm_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            rdata_q     <= '0;
            streak_q    <= '0;
            tmo_q       <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            rdata_q     <= rdata_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        rdata_d     = rdata_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        bus_err_d   = bus_err_q;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                // The streak only grows while IF is actually waiting behind DM.
                if (dm_req && (!if_req || (streak_q < MAX_STREAK_C))) begin
                    state_d     = BUSY_DM;
                    owner_dm_d  = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_be_d    = dm_we ? dm_be : '0;
                    streak_d    = if_req ? streak_q + 1'b1 : '0;
                end else if (if_req) begin
                    state_d     = BUSY_IF;
                    owner_dm_d  = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '0;
                    streak_d    = '0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                tmo_d = tmo_q + 1'b1;
                if (mem_ready) begin
                    rdata_d   = mem_we_q ? '0 : mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end else if (TMO_EN && (tmo_q == TMO_LAST_C)) begin
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                tmo_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_valid  = (state_q == RESP) && !owner_dm_q;
    assign dm_valid  = (state_q == RESP) &&  owner_dm_q;
    assign if_rdata  = rdata_q;
    assign dm_rdata  = rdata_q;
    assign if_stall  = if_req & ~if_valid;
    assign dm_stall  = dm_req & ~dm_valid;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: table-driven access scenarios checked through a
// grant/response scoreboard, plus hand sequences for timeout and mid-access reset.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(4), .TIMEOUT(8), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        if_on;
        logic [31:0] if_addr;
        int          dm_n;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [3:0]  dm_be;
        int          waits;
        int          exp_dm_first;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } grant_t;

    typedef struct {
        logic        is_dm;
        logic [31:0] data;
    } resp_t;

    grant_t grant_q[$];
    resp_t  resp_q[$];
    int     n_vec = 0;
    int     n_bad = 0;

    int     mem_waits   = 0;
    logic   mem_on      = 1'b1;
    logic   force_ready = 1'b0;
    int     wcnt        = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h00500093;
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: unexpected event", name);
    endtask

    // Memory model: answers after mem_waits wait states; force_ready injects stray pulses.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (force_ready) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hBAD0_0001;
            end else if (mem_on && mem_req) begin
                if (wcnt == mem_waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_fn(mem_addr);
                    wcnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic push_dm(input vec_t v, input int i);
        grant_t g;
        resp_t  r;
        g.addr  = v.dm_addr + 32'(4 * i);
        g.we    = v.dm_we;
        g.wdata = v.dm_wdata;
        g.be    = v.dm_we ? v.dm_be : 4'h0;
        r.is_dm = 1'b1;
        r.data  = v.dm_we ? 32'h0 : mem_fn(g.addr);
        grant_q.push_back(g);
        resp_q.push_back(r);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        grant_t g;
        grant_t cur;
        resp_t  r;
        int     k;
        int     iter;
        int     first_lat;
        int     req_cycles;
        int     dm_left;
        logic   prev;
        string  p;
        p = $sformatf("v%0d", idx);
        mem_waits = v.waits;
        mem_on    = 1'b1;
        k = v.if_on ? v.exp_dm_first : v.dm_n;
        for (int i = 0; i < k; i++) push_dm(v, i);
        if (v.if_on) begin
            g.addr = v.if_addr; g.we = 1'b0; g.wdata = '0; g.be = 4'h0;
            r.is_dm = 1'b0; r.data = mem_fn(v.if_addr);
            grant_q.push_back(g);
            resp_q.push_back(r);
        end
        for (int i = k; i < v.dm_n; i++) push_dm(v, i);

        @(negedge clk);
        if_req   = v.if_on;
        if_addr  = v.if_addr;
        dm_left  = v.dm_n;
        dm_req   = (v.dm_n > 0);
        dm_we    = v.dm_we;
        dm_addr  = v.dm_addr;
        dm_wdata = v.dm_wdata;
        dm_be    = v.dm_be;
        prev = 1'b0; first_lat = -1; req_cycles = 0; cur = '{default: '0};

        for (iter = 1; iter <= 200; iter++) begin
            @(negedge clk);
            check({p, " if_stall"}, 32'(if_stall), 32'(if_req & ~if_valid));
            check({p, " dm_stall"}, 32'(dm_stall), 32'(dm_req & ~dm_valid));
            if (mem_req) begin
                req_cycles++;
                if (!prev) begin
                    if (grant_q.size() == 0) flag({p, " extra grant"});
                    else cur = grant_q.pop_front();
                end
                check({p, " mem_addr"}, mem_addr, cur.addr);
                check({p, " mem_we"}, 32'(mem_we), 32'(cur.we));
                check({p, " mem_be"}, 32'(mem_be), 32'(cur.be));
                if (cur.we) check({p, " mem_wdata"}, mem_wdata, cur.wdata);
            end
            prev = mem_req;
            if (if_valid && dm_valid) flag({p, " both valid"});
            if (if_valid || dm_valid) begin
                if (first_lat < 0) first_lat = iter;
                if (resp_q.size() == 0) flag({p, " extra valid"});
                else begin
                    r = resp_q.pop_front();
                    check({p, " owner_dm"}, 32'(dm_valid), 32'(r.is_dm));
                    check({p, " rdata"}, dm_valid ? dm_rdata : if_rdata, r.data);
                end
            end
            if (if_valid) if_req = 1'b0;
            if (dm_valid) begin
                dm_left--;
                if (dm_left == 0) dm_req = 1'b0;
                else dm_addr = dm_addr + 32'd4;
            end
            if (resp_q.size() == 0 && !if_req && !dm_req) break;
        end
        if (iter > 200) begin
            flag({p, " timeout waiting for responses"});
            if_req = 1'b0;
            dm_req = 1'b0;
            resp_q.delete();
            grant_q.delete();
        end
        check({p, " first_latency"}, 32'(first_lat), 32'(v.exp_lat));
        check({p, " mem_req_cycles"}, 32'(req_cycles),
              32'((v.dm_n + int'(v.if_on)) * (v.waits + 1)));
        check({p, " leftover_grants"}, 32'(grant_q.size()), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check({p, " idle_quiet"}, {29'd0, mem_req, if_valid, dm_valid}, 32'd0);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int cnt;
        int iter;
        vecs[0] = '{1'b1, 32'h10, 0, 1'b0, 32'h0,   32'h0,        4'h0,    0, 0, 2};
        vecs[1] = '{1'b1, 32'h40, 1, 1'b0, 32'h200, 32'h0,        4'h0,    0, 1, 2};
        vecs[2] = '{1'b1, 32'h80, 6, 1'b0, 32'h400, 32'h0,        4'h0,    0, 4, 2};
        vecs[3] = '{1'b0, 32'h0,  1, 1'b1, 32'h300, 32'hDEADBEEF, 4'b0011, 3, 0, 5};
        vecs[4] = '{1'b1, 32'h90, 2, 1'b1, 32'h700, 32'h12345678, 4'b1100, 1, 2, 3};
        vecs[5] = '{1'b1, 32'hA0, 0, 1'b0, 32'h0,   32'h0,        4'h0,    2, 0, 4};
        vecs[6] = '{1'b0, 32'h0,  3, 1'b0, 32'h800, 32'h0,        4'h0,    1, 0, 3};

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; dm_be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_be", 32'(mem_be), 32'd0);
        check("reset valids", {30'd0, if_valid, dm_valid}, 32'd0);
        check("reset rdata", if_rdata | dm_rdata, 32'd0);
        check("reset bus_err", 32'(bus_err), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(i, vecs[i]);
        check("bus_err before timeout", 32'(bus_err), 32'd0);

        // Watchdog: memory never answers.
        mem_on = 1'b0;
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
        cnt = 0;
        for (iter = 1; iter <= 40; iter++) begin
            @(negedge clk);
            if (mem_req) cnt++;
            if (dm_valid) break;
        end
        check("tmo valid_cycle", 32'(iter), 32'd9);
        check("tmo mem_req_cycles", 32'(cnt), 32'd8);
        check("tmo dm_rdata", dm_rdata, 32'd0);
        check("tmo bus_err", 32'(bus_err), 32'd1);
        dm_req = 1'b0;
        repeat (3) @(negedge clk);
        check("tmo bus_err sticky", 32'(bus_err), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("tmo bus_err reset", 32'(bus_err), 32'd0);
        mem_on = 1'b1;

        // Reset during BUSY_DM followed by stray mem_ready pulses.
        mem_waits = 5;
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
        repeat (2) @(negedge clk);
        check("rst busy mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        check("rst drop mem_req", 32'(mem_req), 32'd0);
        rst_n = 1'b1;
        force_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) force_ready = 1'b0;
            check($sformatf("rst quiet c%0d", i),
                  {29'd0, mem_req, if_valid, dm_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
